// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard/stall sequencer with CGRA request/done handshake and stall counter
module pipeline_stall_ctrl #(
    parameter int CGRA_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rd_i,
    input  logic [4:0]       IFID_Rs1_i,
    input  logic [4:0]       IFID_Rs2_i,
    input  logic             Branch_taken_i,
    input  logic             dmem_stall_i,
    input  logic             cgra_start_i,
    input  logic             cgra_ack_i,
    input  logic             cgra_done_i,
    output logic             Stall_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             Hold_o,
    output logic             Flush_o,
    output logic             cgra_req_o,
    output logic             cgra_wb_o,
    output logic             cgra_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, CGRA_REQ, CGRA_BUSY} state_t;
    state_t state, next;
    logic [15:0] tcnt;
    logic load_use, tmo;
    assign load_use = IDEX_MemRead_i & (IDEX_Rd_i != 5'd0) &
                      (IDEX_Rd_i == IFID_Rs1_i | IDEX_Rd_i == IFID_Rs2_i);
    assign tmo = tcnt == 16'(CGRA_TIMEOUT - 1);
    always_comb begin
        next        = state;
        Stall_o     = 1'b0;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        Hold_o      = 1'b1;
        case (state)
            RUN:
                if (dmem_stall_i) next = MEM_WAIT;
                else if (cgra_start_i) next = CGRA_REQ;
                else begin
                    Hold_o      = 1'b0;
                    Stall_o     = load_use;
                    PCWrite_o   = ~load_use;
                    IFIDWrite_o = ~load_use;
                end
            MEM_WAIT:  next = dmem_stall_i ? MEM_WAIT : RUN;
            CGRA_REQ:  next = cgra_ack_i ? CGRA_BUSY : CGRA_REQ;
            CGRA_BUSY: next = (cgra_done_i | tmo) ? RUN : CGRA_BUSY;
            default:   next = RUN;
        endcase
        // reset forces RUN, but the pipeline must stay frozen while it is held
        if (!rst_i) begin
            Hold_o      = 1'b1;
            Stall_o     = 1'b0;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
        end
    end
    assign Flush_o = Branch_taken_i & ~Hold_o & ~Stall_o;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= RUN;
            tcnt        <= '0;
            cgra_req_o  <= 1'b0;
            cgra_wb_o   <= 1'b0;
            cgra_err_o  <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state      <= next;
            cgra_req_o <= next == CGRA_REQ;
            cgra_wb_o  <= state == CGRA_BUSY && cgra_done_i;
            tcnt       <= state == CGRA_BUSY ? tcnt + 16'd1 : 16'd0;
            if (state == CGRA_BUSY && !cgra_done_i && tmo) cgra_err_o <= 1'b1;
            if ((Hold_o | Stall_o) && ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: vector table, directed CGRA/memory/reset sequences and randomized model check
module tb_pipeline_stall_ctrl;
    localparam int T = 8;
    logic clk_i = 0, rst_i = 0;
    logic mr = 0, br = 0, dmem = 0, start = 0, ack = 0, done = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic stall, pcw, ifw, hold, flush, req, wb, err;
    logic [15:0] cnt;
    int checks = 0, errors = 0;
    bit in_mem, in_req, m_wb, m_err, m_req, e_hold, e_stall;
    int busy_left, m_cnt;

    pipeline_stall_ctrl #(.CGRA_TIMEOUT(T), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .IDEX_MemRead_i(mr), .IDEX_Rd_i(rd),
        .IFID_Rs1_i(rs1), .IFID_Rs2_i(rs2), .Branch_taken_i(br), .dmem_stall_i(dmem),
        .cgra_start_i(start), .cgra_ack_i(ack), .cgra_done_i(done), .Stall_o(stall),
        .PCWrite_o(pcw), .IFIDWrite_o(ifw), .Hold_o(hold), .Flush_o(flush),
        .cgra_req_o(req), .cgra_wb_o(wb), .cgra_err_o(err), .stall_cnt_o(cnt));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        in_mem = 0; in_req = 0; busy_left = 0; m_wb = 0; m_err = 0; m_req = 0; m_cnt = 0;
    endtask

    // compare every output against the model mid-cycle, then advance the model at the edge
    task automatic cycle();
        bit run, lu, e_flush;
        @(negedge clk_i);
        run = !(in_mem || in_req || busy_left > 0);
        lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
        e_hold = !run || dmem || start;
        e_stall = !e_hold && lu;
        e_flush = br && !e_hold && !e_stall;
        chk("hold", hold, e_hold);
        chk("stall", stall, e_stall);
        chk("pcwrite", pcw, !e_hold && !lu);
        chk("ifidwrite", ifw, !e_hold && !lu);
        chk("flush", flush, e_flush);
        chk("req", req, m_req);
        chk("wb", wb, m_wb);
        chk("err", err, m_err);
        chk("stall_cnt", cnt, m_cnt);
        @(posedge clk_i);
        if (e_hold || e_stall) m_cnt = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
        m_wb = busy_left > 0 && done;
        if (busy_left == 1 && !done) m_err = 1;
        if (busy_left > 0) busy_left = (done || busy_left == 1) ? 0 : busy_left - 1;
        else if (in_req) begin
            if (ack) begin in_req = 0; busy_left = T; end
        end
        else if (in_mem) in_mem = dmem;
        else if (dmem) in_mem = 1;
        else if (start) in_req = 1;
        m_req = in_req;
        #1;
    endtask

    task automatic idle();
        mr = 0; rd = 0; rs1 = 0; rs2 = 0; br = 0; dmem = 0; start = 0; ack = 0; done = 0;
    endtask

    task automatic do_reset();
        rst_i = 0;
        @(posedge clk_i);
        #1 rst_i = 1;
        model_reset();
    endtask

    typedef struct {
        logic mr; logic [4:0] rd, rs1, rs2; logic br;
        logic stall, pcw, hold, flush;
    } vec_t;
    vec_t tbl[6];
    int n, wbs;

    initial begin
        tbl[0] = '{1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 5'd9, 5'd8, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        idle();
        model_reset();
        #12;
        chk("rst_hold", hold, 1); chk("rst_pcw", pcw, 0); chk("rst_ifw", ifw, 0);
        chk("rst_stall", stall, 0); chk("rst_flush", flush, 0); chk("rst_req", req, 0);
        chk("rst_wb", wb, 0); chk("rst_err", err, 0); chk("rst_cnt", cnt, 0);
        @(posedge clk_i);
        #1 rst_i = 1;

        // memory wait: 3-cycle dmem pulse gives 4 hold cycles
        n = 0;
        for (int i = 0; i < 6; i++) begin
            dmem = i < 3;
            #1 if (hold) n++;
            cycle();
        end
        chk("mem_hold_cycles", n, 4);
        chk("mem_cnt", cnt, 4);
        chk("mem_back_run", hold, 0);

        for (int i = 0; i < 6; i++) begin
            mr = tbl[i].mr; rd = tbl[i].rd; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; br = tbl[i].br;
            #1;
            chk($sformatf("vec%0d_stall", i), stall, tbl[i].stall);
            chk($sformatf("vec%0d_pcw", i), pcw, tbl[i].pcw);
            chk($sformatf("vec%0d_hold", i), hold, tbl[i].hold);
            chk($sformatf("vec%0d_flush", i), flush, tbl[i].flush);
            cycle();
        end
        chk("lu_cnt", cnt, 6);
        idle();

        // CGRA normal: ack 2 cycles after req, done 6 busy cycles later
        start = 1; cycle(); start = 0;
        chk("req_after_start", req, 1);
        cycle(); cycle();
        ack = 1; cycle(); ack = 0;
        chk("req_cleared", req, 0);
        wbs = 0;
        for (int i = 0; i < 10; i++) begin
            done = i == 5;
            cycle();
            if (wb) begin wbs++; chk("hold_on_wb", hold, 0); end
        end
        chk("normal_wb_count", wbs, 1);
        chk("normal_err", err, 0);
        idle();

        // done on the last legal busy cycle wins over timeout
        start = 1; cycle(); start = 0; ack = 1; cycle(); ack = 0;
        repeat (T - 1) cycle();
        done = 1; cycle(); done = 0;
        chk("late_done_wb", wb, 1);
        chk("late_done_err", err, 0);
        cycle();

        // timeout: no done for T busy cycles
        start = 1; cycle(); start = 0; ack = 1; cycle(); ack = 0;
        wbs = 0;
        for (int i = 0; i < T - 1; i++) begin cycle(); if (wb) wbs++; end
        chk("tmo_still_busy", hold, 1);
        cycle();
        chk("tmo_run", hold, 0);
        chk("tmo_err", err, 1);
        cycle(); if (wb) wbs++;
        chk("tmo_no_wb", wbs, 0);
        repeat (3) cycle();
        chk("err_sticky", err, 1);

        // priority: everything at once; memory first, CGRA after release
        dmem = 1; start = 1; mr = 1; rd = 5; rs2 = 5; br = 1;
        #1 chk("prio_flush", flush, 0); chk("prio_stall", stall, 0); chk("prio_hold", hold, 1);
        cycle(); dmem = 0;
        cycle();
        cycle(); start = 0;
        chk("prio_req", req, 1);
        idle();
        ack = 1; cycle(); ack = 0; done = 1; cycle(); done = 0; cycle();

        // async reset mid-busy
        do_reset();
        start = 1; cycle(); start = 0; cycle(); ack = 1; cycle(); ack = 0; cycle();
        #2 rst_i = 0;
        #1 chk("arst_req", req, 0); chk("arst_hold", hold, 1); chk("arst_cnt", cnt, 0);
        @(posedge clk_i);
        #1 rst_i = 1;
        model_reset();
        done = 1; cycle(); done = 0;
        chk("arst_no_wb", wb, 0);
        cycle();
        chk("arst_no_wb2", wb, 0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            mr = $urandom_range(0, 1); rd = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            br = $urandom_range(0, 1); dmem = $urandom_range(0, 9) == 0;
            start = $urandom_range(0, 9) == 0; ack = $urandom_range(0, 2) == 0;
            done = $urandom_range(0, 9) == 0;
            cycle();
        end
        idle();

        // counter saturation under a long hold
        do_reset();
        dmem = 1;
        repeat (65540) @(posedge clk_i);
        #1 chk("sat_cnt", cnt, 16'hFFFF);
        @(posedge clk_i);
        #1 chk("sat_cnt_hold", cnt, 16'hFFFF);
        chk("sat_hold", hold, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
